// File: rtl/audio_vol_pkg.sv
// Shared types and saturating helpers for the audio volume sequencer.
// Gain is volumeBin12/2048, so VOL_UNITY is 0 dB.
package audio_vol_pkg;

  localparam int VOL_W = 12;
  localparam logic [VOL_W-1:0] VOL_UNITY = 12'd2048;

  typedef logic [VOL_W-1:0] vol_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP_UP = 2'd1,
    RAMP_DN = 2'd2,
    MUTED   = 2'd3
  } vol_state_t;

  // The sum is formed one bit wider, so a step near full scale clamps instead of wrapping.
  function automatic vol_t vol_add_sat(input vol_t v, input vol_t step, input vol_t lim);
    logic [VOL_W:0] sum;
    sum = {1'b0, v} + {1'b0, step};
    return (sum > {1'b0, lim}) ? lim : sum[VOL_W-1:0];
  endfunction

  function automatic vol_t vol_sub_sat(input vol_t v, input vol_t step);
    return (v < step) ? '0 : (v - step);
  endfunction

endpackage

// File: rtl/volume_ctrl_btn_repeat.sv
// Button edge detect plus hold/auto-repeat: one step on press, another after
// HOLD_SMPLS held sample strobes, then one every REPEAT_SMPLS strobes.
module btn_repeat #(
  parameter int HOLD_SMPLS   = 24000,
  parameter int REPEAT_SMPLS = 4800
) (
  input  logic clk,
  input  logic rst_n,
  input  logic smpl_valid,
  input  logic btn,
  output logic step
);

  localparam int CNT_MAX = (HOLD_SMPLS > REPEAT_SMPLS) ? HOLD_SMPLS : REPEAT_SMPLS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             rpt;

  assign rise = btn & ~btn_q;
  assign rpt  = btn & btn_q & smpl_valid & (cnt == CNT_W'(1));
  assign step = rise | rpt;

  // Down-counter to the next repeat; a strobe in the press cycle itself is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      cnt   <= '0;
    end else begin
      btn_q <= btn;
      if (!btn) begin
        cnt <= '0;
      end else if (rise) begin
        cnt <= CNT_W'(HOLD_SMPLS);
      end else if (smpl_valid && (cnt != '0)) begin
        cnt <= (cnt == CNT_W'(1)) ? CNT_W'(REPEAT_SMPLS) : (cnt - CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/volume_ctrl.sv
// Volume sequencer: buttons and mute set a target, applied gain ramps per sample.
// Build option AUDIO_SOFT_START_EN: fade in from silence to VOL_RESET after reset.
//
// state   | meaning
// IDLE    | applied gain equals target, not muted
// RAMP_UP | applied gain below effective target, stepping up on strobes
// RAMP_DN | applied gain above effective target, stepping down on strobes
// MUTED   | muted and applied gain has reached 0
module volume_ctrl
  import audio_vol_pkg::*;
#(
  parameter vol_t VOL_MAX      = 12'd4095,
  parameter vol_t VOL_RESET    = 12'd1024,
  parameter vol_t BTN_STEP     = 12'd64,
  parameter vol_t RAMP_STEP    = 12'd8,
  parameter int   HOLD_SMPLS   = 24000,
  parameter int   REPEAT_SMPLS = 4800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smpl_valid,
  input  logic             vol_up,
  input  logic             vol_dn,
  input  logic             mute_tgl,
  output logic [VOL_W-1:0] volumeBin12,
  output logic [VOL_W-1:0] target_vol,
  output logic             muted,
  output logic             ramping
);

`ifdef AUDIO_SOFT_START_EN
  localparam vol_t       GAIN_RST  = '0;
  localparam vol_state_t STATE_RST = RAMP_UP;
`else
  localparam vol_t       GAIN_RST  = VOL_RESET;
  localparam vol_state_t STATE_RST = IDLE;
`endif

  vol_state_t state;
  vol_state_t state_nxt;
  vol_t       eff;
  vol_t       eff_nxt;
  vol_t       gain_nxt;
  vol_t       target_nxt;
  logic       muted_nxt;
  logic       up_step;
  logic       dn_step;
  logic       up_solo;
  logic       dn_solo;

  // Both buttons down is treated as neither, which also holds both repeat counters at 0.
  assign up_solo = vol_up & ~vol_dn;
  assign dn_solo = vol_dn & ~vol_up;

  btn_repeat #(
    .HOLD_SMPLS  (HOLD_SMPLS),
    .REPEAT_SMPLS(REPEAT_SMPLS)
  ) u_btn_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .smpl_valid(smpl_valid),
    .btn       (up_solo),
    .step      (up_step)
  );

  btn_repeat #(
    .HOLD_SMPLS  (HOLD_SMPLS),
    .REPEAT_SMPLS(REPEAT_SMPLS)
  ) u_btn_dn (
    .clk       (clk),
    .rst_n     (rst_n),
    .smpl_valid(smpl_valid),
    .btn       (dn_solo),
    .step      (dn_step)
  );

  always_comb begin
    eff        = muted ? '0 : target_vol;
    target_nxt = target_vol;
    muted_nxt  = muted ^ mute_tgl;
    gain_nxt   = volumeBin12;

    if (up_step && !dn_step) begin
      target_nxt = vol_add_sat(target_vol, BTN_STEP, VOL_MAX);
    end else if (dn_step && !up_step) begin
      target_nxt = vol_sub_sat(target_vol, BTN_STEP);
    end

    // The step direction follows eff, so a mute mid ramp-up turns around without overshoot.
    if (smpl_valid && ((state == RAMP_UP) || (state == RAMP_DN))) begin
      if (eff > volumeBin12) begin
        gain_nxt = ((eff - volumeBin12) <= RAMP_STEP) ? eff : (volumeBin12 + RAMP_STEP);
      end else if (eff < volumeBin12) begin
        gain_nxt = ((volumeBin12 - eff) <= RAMP_STEP) ? eff : (volumeBin12 - RAMP_STEP);
      end
    end

    // State is derived from the values being registered, so ramping tracks volumeBin12 exactly.
    eff_nxt = muted_nxt ? '0 : target_nxt;
    if (gain_nxt == eff_nxt) begin
      state_nxt = muted_nxt ? MUTED : IDLE;
    end else if (eff_nxt > gain_nxt) begin
      state_nxt = RAMP_UP;
    end else begin
      state_nxt = RAMP_DN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= STATE_RST;
      volumeBin12 <= GAIN_RST;
      target_vol  <= VOL_RESET;
      muted       <= 1'b0;
      ramping     <= (GAIN_RST != VOL_RESET);
    end else begin
      state       <= state_nxt;
      volumeBin12 <= gain_nxt;
      target_vol  <= target_nxt;
      muted       <= muted_nxt;
      ramping     <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DN);
    end
  end

endmodule

// File: tb/tb_volume_ctrl.sv
// Self-checking bench for volume_ctrl: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_volume_ctrl;
  import audio_vol_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        smpl_valid;
  logic        vol_up;
  logic        vol_dn;
  logic        mute_tgl;
  logic [11:0] volumeBin12;
  logic [11:0] target_vol;
  logic        muted;
  logic        ramping;

  int tests;
  int failures;

`ifdef AUDIO_SOFT_START_EN
  localparam int GAIN_RST  = 0;
  localparam int RAMP_RST  = 1;
  localparam int STATE_RST = 1;
`else
  localparam int GAIN_RST  = 1024;
  localparam int RAMP_RST  = 0;
  localparam int STATE_RST = 0;
`endif

  typedef enum int {OP_NONE, OP_UP, OP_DN, OP_BOTH, OP_MUTE} op_e;
  typedef struct {
    op_e op;
    int  exp_target;
    int  exp_muted;
    int  exp_gain;
  } vec_t;

  vec_t vecs[10];

  volume_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smpl_valid (smpl_valid),
    .vol_up     (vol_up),
    .vol_dn     (vol_dn),
    .mute_tgl   (mute_tgl),
    .volumeBin12(volumeBin12),
    .target_vol (target_vol),
    .muted      (muted),
    .ramping    (ramping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobes(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) smpl_valid = 1'b1;
      @(negedge clk) smpl_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic press(input logic up, input logic dn);
    @(negedge clk);
    vol_up = up;
    vol_dn = dn;
    repeat (2) @(negedge clk);
    vol_up = 1'b0;
    vol_dn = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_mute();
    @(negedge clk) mute_tgl = 1'b1;
    @(negedge clk) mute_tgl = 1'b0;
  endtask

  task automatic do_reset(input bit settle);
    @(negedge clk);
    rst_n      = 1'b0;
    smpl_valid = 1'b0;
    vol_up     = 1'b0;
    vol_dn     = 1'b0;
    mute_tgl   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef AUDIO_SOFT_START_EN
    if (settle) strobes(128, 3);
`else
    if (settle) @(negedge clk);
`endif
  endtask

  task automatic apply_op(input op_e op);
    case (op)
      OP_UP:   press(1'b1, 1'b0);
      OP_DN:   press(1'b0, 1'b1);
      OP_BOTH: press(1'b1, 1'b1);
      OP_MUTE: pulse_mute();
      default: @(negedge clk);
    endcase
  endtask

  initial begin
    tests      = 0;
    failures   = 0;
    rst_n      = 1'b0;
    smpl_valid = 1'b0;
    vol_up     = 1'b0;
    vol_dn     = 1'b0;
    mute_tgl   = 1'b0;

    vecs[0] = '{OP_UP,   1088, 0, 1088};
    vecs[1] = '{OP_UP,   1152, 0, 1152};
    vecs[2] = '{OP_DN,   1088, 0, 1088};
    vecs[3] = '{OP_BOTH, 1088, 0, 1088};
    vecs[4] = '{OP_MUTE, 1088, 1, 0};
    vecs[5] = '{OP_UP,   1152, 1, 0};
    vecs[6] = '{OP_DN,   1088, 1, 0};
    vecs[7] = '{OP_MUTE, 1088, 0, 1088};
    vecs[8] = '{OP_DN,   1024, 0, 1024};
    vecs[9] = '{OP_DN,    960, 0, 960};

    // Reset values
    do_reset(1'b0);
    check("rst_gain", int'(volumeBin12), GAIN_RST);
    check("rst_target", int'(target_vol), 1024);
    check("rst_muted", int'(muted), 0);
    check("rst_ramping", int'(ramping), RAMP_RST);
    check("rst_state", int'(dut.state), STATE_RST);
`ifdef AUDIO_SOFT_START_EN
    strobes(1, 3);
    check("soft_first", int'(volumeBin12), 8);
    strobes(126, 3);
    check("soft_127", int'(volumeBin12), 1016);
    check("soft_ramping", int'(ramping), 1);
    strobes(1, 3);
    check("soft_done", int'(volumeBin12), 1024);
    check("soft_ramp_off", int'(ramping), 0);
    check("soft_idle", int'(dut.state), int'(IDLE));
`endif

    // Single press, held well under the hold time
    do_reset(1'b1);
    @(negedge clk) vol_up = 1'b1;
    @(negedge clk);
    check("press_target", int'(target_vol), 1088);
    check("press_ramping", int'(ramping), 1);
    strobes(7, 3);
    check("press_7", int'(volumeBin12), 1080);
    strobes(1, 3);
    check("press_8", int'(volumeBin12), 1088);
    check("press_idle", int'(ramping), 0);
    strobes(20, 0);
    check("press_held_norpt", int'(target_vol), 1088);
    vol_up = 1'b0;

    // Vector table
    do_reset(1'b1);
    for (int v = 0; v < 10; v++) begin
      apply_op(vecs[v].op);
      strobes(200, 0);
      check($sformatf("vec%0d_target", v), int'(target_vol), vecs[v].exp_target);
      check($sformatf("vec%0d_muted", v), int'(muted), vecs[v].exp_muted);
      check($sformatf("vec%0d_gain", v), int'(volumeBin12), vecs[v].exp_gain);
      check($sformatf("vec%0d_ramping", v), int'(ramping), 0);
    end

    // Saturation at both ends, target 960 from the table
    for (int i = 0; i < 48; i++) press(1'b1, 1'b0);
    check("sat_4032", int'(target_vol), 4032);
    press(1'b1, 1'b0);
    check("sat_hi", int'(target_vol), 4095);
    press(1'b1, 1'b0);
    check("sat_hi_again", int'(target_vol), 4095);
    press(1'b0, 1'b1);
    check("sat_hi_dn", int'(target_vol), 4031);
    for (int i = 0; i < 62; i++) press(1'b0, 1'b1);
    check("sat_63", int'(target_vol), 63);
    press(1'b0, 1'b1);
    check("sat_lo", int'(target_vol), 0);
    press(1'b0, 1'b1);
    check("sat_lo_again", int'(target_vol), 0);

    // Hold with auto-repeat, one strobe per clock
    do_reset(1'b1);
    @(negedge clk) vol_up = 1'b1;
    @(negedge clk) smpl_valid = 1'b1;
    for (int k = 1; k <= 33600; k++) begin
      @(negedge clk);
      if (k == 23999) check("hold_pre", int'(target_vol), 1088);
      if (k == 24000) check("hold_first_rpt", int'(target_vol), 1152);
      if (k == 28799) check("hold_pre2", int'(target_vol), 1152);
      if (k == 28800) check("hold_second_rpt", int'(target_vol), 1216);
    end
    smpl_valid = 1'b0;
    vol_up     = 1'b0;
    @(negedge clk);
    check("hold_total", int'(target_vol), 1280);

    // Mute ramp to silence, buttons while muted, unmute
    do_reset(1'b1);
    pulse_mute();
    check("mute_muted", int'(muted), 1);
    check("mute_ramping", int'(ramping), 1);
    strobes(127, 3);
    check("mute_127", int'(volumeBin12), 8);
    strobes(1, 3);
    check("mute_zero", int'(volumeBin12), 0);
    check("mute_state", int'(dut.state), int'(MUTED));
    check("mute_ramp_off", int'(ramping), 0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    strobes(10, 1);
    check("mute_dn_target", int'(target_vol), 896);
    check("mute_dn_gain", int'(volumeBin12), 0);
    pulse_mute();
    check("unmute_state", int'(dut.state), int'(RAMP_UP));
    strobes(111, 1);
    check("unmute_111", int'(volumeBin12), 888);
    strobes(1, 1);
    check("unmute_done", int'(volumeBin12), 896);
    check("unmute_idle", int'(dut.state), int'(IDLE));

    // Mute mid ramp-up, then mute toggle coinciding with a strobe
    do_reset(1'b1);
    pulse_mute();
    strobes(128, 1);
    pulse_mute();
    strobes(64, 1);
    check("mid_512", int'(volumeBin12), 512);
    pulse_mute();
    strobes(1, 1);
    check("mid_504", int'(volumeBin12), 504);
    check("mid_state_dn", int'(dut.state), int'(RAMP_DN));
    @(negedge clk);
    mute_tgl   = 1'b1;
    smpl_valid = 1'b1;
    @(negedge clk);
    mute_tgl   = 1'b0;
    smpl_valid = 1'b0;
    check("sim_gain", int'(volumeBin12), 496);
    check("sim_muted", int'(muted), 0);
    check("sim_state_up", int'(dut.state), int'(RAMP_UP));

    // Both buttons rising together
    do_reset(1'b1);
    @(negedge clk);
    vol_up = 1'b1;
    vol_dn = 1'b1;
    strobes(5, 0);
    check("both_held", int'(target_vol), 1024);
    vol_up = 1'b0;
    vol_dn = 1'b0;
    repeat (2) @(negedge clk);
    check("both_released", int'(target_vol), 1024);

    // Asynchronous reset mid ramp
    do_reset(1'b1);
    pulse_mute();
    strobes(4, 1);
    check("abort_pre", int'(volumeBin12), 992);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_gain", int'(volumeBin12), GAIN_RST);
    check("abort_target", int'(target_vol), 1024);
    check("abort_muted", int'(muted), 0);
    check("abort_ramping", int'(ramping), RAMP_RST);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
